// File: rtl/scariv_vlsu_step_sequencer_if.sv
// Signal bundle between the vector LSU step sequencer and its neighbours:
// vector dispatch, the address generator, the LSU issue queue and its credit return.
interface scariv_vlsu_step_sequencer_if #(
   parameter int LMUL_MAX   = 8,
   parameter int VEC_STEP_W = 4
);
   localparam int LW = $clog2(LMUL_MAX) + 1;
   localparam int SW = $clog2(VEC_STEP_W);

   // Handshake: an instruction is taken on a rising edge where i_instr_valid and
   // o_instr_ready are both high and i_flush_valid is low; o_instr_ready never
   // depends on i_instr_valid. o_pipe_valid writes one beat per cycle it is high.
   logic          i_flush_valid;
   logic          i_instr_valid;
   logic          o_instr_ready;
   logic [LW-1:0] i_instr_lmul_num;
   logic [4:0]    i_instr_vd;
   logic          o_ag_valid;
   logic          o_ag_is_last_lmul_index;
   logic [SW-1:0] o_ag_vec_step_index;
   logic          i_ag_stall;
   logic          i_ag_req_splitted;
   logic          o_pipe_valid;
   logic [4:0]    o_pipe_vreg;
   logic [SW-1:0] o_pipe_step;
   logic          o_pipe_split_2nd;
   logic          i_credit_return;
   logic          o_done;
   logic          o_busy;
   logic [1:0]    o_dbg_state;

   modport slave (
      input  i_flush_valid, i_instr_valid, i_instr_lmul_num, i_instr_vd,
             i_ag_stall, i_ag_req_splitted, i_credit_return,
      output o_instr_ready, o_ag_valid, o_ag_is_last_lmul_index, o_ag_vec_step_index,
             o_pipe_valid, o_pipe_vreg, o_pipe_step, o_pipe_split_2nd,
             o_done, o_busy, o_dbg_state
   );

   modport master (
      output i_flush_valid, i_instr_valid, i_instr_lmul_num, i_instr_vd,
             i_ag_stall, i_ag_req_splitted, i_credit_return,
      input  o_instr_ready, o_ag_valid, o_ag_is_last_lmul_index, o_ag_vec_step_index,
             o_pipe_valid, o_pipe_vreg, o_pipe_step, o_pipe_split_2nd,
             o_done, o_busy, o_dbg_state
   );
endinterface

// File: rtl/scariv_vlsu_step_sequencer.sv
// Walks a unit-stride vector memory op over every register and DLEN step, one step
// per cycle, holding back issue until the LSU queue can take both halves of a split.
module scariv_vlsu_step_sequencer #(
   parameter int LMUL_MAX   = 8,
   parameter int VEC_STEP_W = 4,
   parameter int CREDITS    = 4
) (
   input logic i_clk,
   input logic i_reset,
   scariv_vlsu_step_sequencer_if.slave sq_if
);
   localparam int LW = $clog2(LMUL_MAX) + 1;
   localparam int SW = $clog2(VEC_STEP_W);
   localparam int CW = $clog2(CREDITS + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_SPLIT = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e        state_q;
   logic [4:0]    vd_q;
   logic [LW-1:0] lmul_num_q;
   logic [LW-1:0] lmul_idx_q;
   logic [SW-1:0] step_idx_q;
   logic [CW-1:0] credit_q;
   logic [CW-1:0] credit_d;

   logic ag_valid;
   logic beat;
   logic last_lmul;
   logic last_step;
   logic ret_ok;

   // Two credits are needed to issue so a split's second half always has a slot.
   assign ag_valid  = (state_q == S_ISSUE) && (credit_q >= CW'(2));
   assign beat      = ag_valid || (state_q == S_SPLIT);
   assign last_lmul = (lmul_idx_q == lmul_num_q - LW'(1));
   assign last_step = (step_idx_q == SW'(VEC_STEP_W - 1));
   assign ret_ok    = sq_if.i_credit_return && (credit_q != CW'(CREDITS));

   always_comb begin
      credit_d = credit_q;
      if (beat && !ret_ok) begin
         credit_d = credit_q - CW'(1);
      end else if (!beat && ret_ok) begin
         credit_d = credit_q + CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= S_IDLE;
         vd_q       <= '0;
         lmul_num_q <= '0;
         lmul_idx_q <= '0;
         step_idx_q <= '0;
         credit_q   <= CW'(CREDITS);
      end else begin
         credit_q <= credit_d;
         if (sq_if.i_flush_valid) begin
            state_q <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (sq_if.i_instr_valid) begin
                     vd_q       <= sq_if.i_instr_vd;
                     lmul_num_q <= sq_if.i_instr_lmul_num;
                     lmul_idx_q <= '0;
                     step_idx_q <= '0;
                     state_q    <= S_ISSUE;
                  end
               end
               S_ISSUE, S_SPLIT: begin
                  // A stalled ISSUE beat is replayed as the split's second half.
                  if (state_q == S_ISSUE && ag_valid && sq_if.i_ag_stall) begin
                     state_q <= S_SPLIT;
                  end else if (beat) begin
                     step_idx_q <= step_idx_q + SW'(1);
                     if (last_step && !last_lmul) begin
                        lmul_idx_q <= lmul_idx_q + LW'(1);
                     end
                     state_q <= (last_step && last_lmul) ? S_DONE : S_ISSUE;
                  end
               end
               S_DONE: begin
                  state_q <= S_IDLE;
               end
               default: begin
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign sq_if.o_instr_ready           = (state_q == S_IDLE);
   assign sq_if.o_busy                  = (state_q != S_IDLE);
   assign sq_if.o_done                  = (state_q == S_DONE);
   assign sq_if.o_ag_valid              = ag_valid;
   assign sq_if.o_ag_is_last_lmul_index = last_lmul;
   assign sq_if.o_ag_vec_step_index     = step_idx_q;
   assign sq_if.o_pipe_valid            = beat;
   assign sq_if.o_pipe_vreg             = vd_q + 5'(lmul_idx_q);
   assign sq_if.o_pipe_step             = step_idx_q;
   assign sq_if.o_pipe_split_2nd        = (state_q == S_SPLIT);
   assign sq_if.o_dbg_state             = state_q;

   a_split_needs_2nd_half: assert property (@(posedge i_clk) disable iff (i_reset)
      (state_q == S_SPLIT && !sq_if.i_flush_valid) |-> sq_if.i_ag_req_splitted);

   a_no_return_when_full: assert property (@(posedge i_clk) disable iff (i_reset)
      sq_if.i_credit_return |-> (credit_q != CW'(CREDITS)));
endmodule
